// File: rtl/vga_text_pkg.sv
// Shared geometry constants, controller states and the glyph table for the VGA text renderer.
package vga_text_pkg;

    localparam int unsigned H_DISP   = 640;
    localparam int unsigned V_DISP   = 480;
    localparam int unsigned CHAR_W   = 8;
    localparam int unsigned CHAR_H   = 16;
    localparam int unsigned COLS     = H_DISP / CHAR_W;
    localparam int unsigned ROWS     = V_DISP / CHAR_H;
    localparam int unsigned CELLS    = COLS * ROWS;
    localparam int unsigned PIPE_LAT = 3;

    localparam int unsigned CELL_W   = 12;
    localparam int unsigned FONT_AW  = 11;
    localparam int unsigned COORD_W  = 10;
    localparam int unsigned RGB_W    = 24;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // One 8-bit glyph row; bit 7 is the leftmost pixel. Undrawn codes show a hollow box.
    function automatic logic [7:0] font_glyph(input logic [6:0] code, input logic [3:0] row);
        logic [127:0] g;
        logic [6:0]   base;
        case (code)
            7'h00, 7'h20: g = '0;
            7'h41:        g = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
            7'h48:        g = 128'h0000_C6C6_C6C6_FEC6_C6C6_C6C6_0000_0000;
            default:      g = 128'h0000_7E42_4242_4242_4242_4242_7E00_0000;
        endcase
        base = {~row, 3'b111};
        return g[base -: 8];
    endfunction

endpackage

// File: rtl/vga_font_rom.sv
// 2048x8 glyph ROM (16 rows per code), one-cycle synchronous read.
module vga_font_rom
    import vga_text_pkg::*;
(
    input  logic               clk,
    input  logic [FONT_AW-1:0] addr,
    output logic [7:0]         data
);

    always_ff @(posedge clk) begin
        data <= font_glyph(addr[10:4], addr[3:0]);
    end

endmodule

// File: rtl/vga_text_render.sv
// 80x30 text-mode renderer: clear-on-reset text RAM, write port, and a 3-stage pixel pipeline.
module vga_text_render
    import vga_text_pkg::*;
#(
    parameter logic [23:0] FG_COLOR   = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR   = 24'h000000,
    parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
    input  logic              vga_clk,
    input  logic              sys_rst,
    input  logic [9:0]        pixel_xpos,
    input  logic [9:0]        pixel_ypos,
    output logic [23:0]       pixel_data,
    input  logic              wr_en,
    input  logic [11:0]       wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_ready
);

    state_t              state, state_n;
    logic [CELL_W-1:0]   clr_addr, clr_addr_n;

    logic                ram_we;
    logic [CELL_W-1:0]   ram_waddr;
    logic [7:0]          ram_wdata;
    logic [7:0]          text_ram [CELLS];

    logic                in_range_c;
    logic [CELL_W-1:0]   cell_c;

    logic [CELL_W-1:0]   s1_cell;
    logic [3:0]          s1_row;
    logic [2:0]          s1_bit;
    logic                s1_vld;

    logic [6:0]          s2_char;
    logic [3:0]          s2_row;
    logic [2:0]          s2_bit;
    logic                s2_vld;

    logic [7:0]          font_byte;
    logic [2:0]          s3_bit;
    logic                s3_vld;

    // Controller state register
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            wr_ready <= 1'b0;
        end else begin
            state    <= state_n;
            clr_addr <= clr_addr_n;
            wr_ready <= (state_n == RUN);
        end
    end

    // Clear sweep owns the RAM write port until the last cell is written
    always_comb begin
        state_n    = state;
        clr_addr_n = clr_addr;
        ram_we     = 1'b0;
        ram_waddr  = wr_addr;
        ram_wdata  = wr_data;
        case (state)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_addr;
                ram_wdata = CLEAR_CHAR;
                if (clr_addr == CELL_W'(CELLS - 1)) begin
                    state_n = RUN;
                end else begin
                    clr_addr_n = clr_addr + CELL_W'(1);
                end
            end
            RUN: begin
                ram_we = wr_en && wr_ready && (wr_addr < CELL_W'(CELLS));
            end
            default: state_n = CLEAR;
        endcase
    end

    assign in_range_c = (pixel_xpos < COORD_W'(H_DISP)) && (pixel_ypos < COORD_W'(V_DISP));
    assign cell_c     = CELL_W'(pixel_ypos[9:4]) * CELL_W'(COLS) + CELL_W'(pixel_xpos[9:3]);

    // S1: coordinate decode; out-of-range reads are steered to cell 0
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            s1_cell <= '0;
            s1_row  <= '0;
            s1_bit  <= '0;
            s1_vld  <= 1'b0;
        end else begin
            s1_cell <= in_range_c ? cell_c : '0;
            s1_row  <= pixel_ypos[3:0];
            s1_bit  <= pixel_xpos[2:0];
            s1_vld  <= in_range_c;
        end
    end

    // S2: text RAM, read-first on a same-cell collision
    always_ff @(posedge vga_clk) begin
        if (ram_we) begin
            text_ram[ram_waddr] <= ram_wdata;
        end
        s2_char <= text_ram[s1_cell][6:0];
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            s2_row <= '0;
            s2_bit <= '0;
            s2_vld <= 1'b0;
            s3_bit <= '0;
            s3_vld <= 1'b0;
        end else begin
            s2_row <= s1_row;
            s2_bit <= s1_bit;
            s2_vld <= s1_vld;
            s3_bit <= s2_bit;
            s3_vld <= s2_vld;
        end
    end

    // S3: glyph row fetch, aligned with s3_bit/s3_vld
    vga_font_rom u_font_rom (
        .clk  (vga_clk),
        .addr ({s2_char, s2_row}),
        .data (font_byte)
    );

    // Pure select over stage-3 flops; bit 7 of the glyph row is the leftmost pixel
    always_comb begin
        pixel_data = '0;
        if (s3_vld) begin
            pixel_data = font_byte[~s3_bit] ? FG_COLOR : BG_COLOR;
        end
    end

endmodule
